// File: rtl/coord_gen.sv
// coord_gen: raster-order fixed-point complex-plane coordinate generator, LANES pixels per beat
module coord_gen #(
    parameter int Q       = 11,
    parameter int N       = 16,
    parameter int LANES   = 4,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int GRID_SH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [N-1:0]       x_min,
    input  logic [N-1:0]       y_max,
    input  logic [1:0]         zoom_level,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*N-1:0] c_real,
    output logic [N-1:0]       c_img,
    output logic [15:0]        px_x,
    output logic [15:0]        px_y,
    output logic               busy,
    output logic               frame_done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    if (Q >= N || LANES < 1 || LANES > 8 || H_RES % LANES != 0) begin : g_bad_params
        $error("coord_gen: illegal parameter combination");
    end

    state_t             state;
    logic [N-1:0]       xmin_r;
    logic [N-1:0]       ymax_r;
    logic [1:0]         zoom_r;
    logic [N-1:0]       g_r;
    logic [N-1:0]       stride;
    logic [LANES*N-1:0] offs;
    logic [N-1:0]       step;
    logic [N-1:0]       nxt_x;
    logic               fire;
    logic               row_end;
    logic               last;

    // grid step from the latched zoom (clamped to 1 LSB), and the next lane-0 coordinate
    always_comb begin
        step    = (int'(zoom_r) > GRID_SH) ? N'(1) : N'(1) << (GRID_SH - int'(zoom_r));
        fire    = out_valid && out_ready;
        row_end = px_x == 16'(H_RES - LANES);
        last    = row_end && px_y == 16'(V_RES - 1);
        nxt_x   = row_end ? xmin_r : c_real[N-1:0] + stride;
    end

    // frame FSM with registered outputs and the incremental coordinate accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            xmin_r     <= '0;
            ymax_r     <= '0;
            zoom_r     <= '0;
            g_r        <= '0;
            stride     <= '0;
            offs       <= '0;
            c_real     <= '0;
            c_img      <= '0;
            px_x       <= '0;
            px_y       <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= LOAD;
                    busy   <= 1'b1;
                    xmin_r <= x_min;
                    ymax_r <= y_max;
                    zoom_r <= zoom_level;
                end
                LOAD: begin
                    state     <= RUN;
                    g_r       <= step;
                    stride    <= N'(LANES) * step;
                    for (int k = 0; k < LANES; k++) begin
                        offs[k*N +: N]   <= N'(k) * step;
                        c_real[k*N +: N] <= xmin_r + N'(k) * step;
                    end
                    c_img     <= ymax_r;
                    px_x      <= '0;
                    px_y      <= '0;
                    out_valid <= 1'b1;
                end
                RUN: if (abort || (fire && last)) begin
                    state      <= DONE;
                    out_valid  <= 1'b0;
                    frame_done <= 1'b1;
                end else if (fire) begin
                    for (int k = 0; k < LANES; k++)
                        c_real[k*N +: N] <= nxt_x + offs[k*N +: N];
                    px_x  <= row_end ? 16'd0 : px_x + 16'(LANES);
                    px_y  <= row_end ? px_y + 16'd1 : px_y;
                    c_img <= row_end ? c_img - g_r : c_img;
                end
                DONE: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    frame_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coord_gen.sv
// tb_coord_gen: directed checks of coord_gen against a closed-form per-beat coordinate model
module tb_coord_gen;
    logic        clk = 0, rst_n = 1, start = 0, abort = 0, out_ready = 1;
    logic [15:0] x_min = 0, y_max = 0;
    logic [1:0]  zoom_level = 0;
    logic        v1, busy1, fd1, v2, busy2, fd2;
    logic [63:0] cr1, cr2;
    logic [15:0] ci1, px1, py1, ci2, px2, py2;
    logic [111:0] cur1, cur2;
    int n_vec = 0, n_err = 0;
    int b, cyc, cnt;

    coord_gen dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_min(x_min), .y_max(y_max),
        .zoom_level(zoom_level), .out_valid(v1), .out_ready(out_ready), .c_real(cr1), .c_img(ci1),
        .px_x(px1), .px_y(py1), .busy(busy1), .frame_done(fd1)
    );

    coord_gen #(.H_RES(8), .V_RES(2), .GRID_SH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .x_min(x_min), .y_max(y_max),
        .zoom_level(zoom_level), .out_valid(v2), .out_ready(out_ready), .c_real(cr2), .c_img(ci2),
        .px_x(px2), .px_y(py2), .busy(busy2), .frame_done(fd2)
    );

    assign cur1 = {py1, px1, ci1, cr1};
    assign cur2 = {py2, px2, ci2, cr2};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // expected {px_y, px_x, c_img, c_real} of beat bi for 4 lanes, bpr beats per row
    function automatic logic [111:0] model(input logic [15:0] xm, input logic [15:0] ym,
                                           input logic [15:0] g, input int bpr, input int bi);
        int x, y;
        logic [63:0] r;
        x = (bi % bpr) * 4;
        y = bi / bpr;
        for (int k = 0; k < 4; k++) r[k*16 +: 16] = xm + 16'((x + k) * int'(g));
        return {16'(y), 16'(x), 16'(ym - 16'(y * int'(g))), r};
    endfunction

    initial begin
        #2 rst_n = 0;
        #1 chk("reset_outs", 128'({v1, busy1, fd1, cur1}), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1;

        // full default frame with mid-frame input changes and a stray start
        x_min = 16'hf800; y_max = 16'h04b0; zoom_level = 0; out_ready = 1; start = 1;
        @(negedge clk) start = 0;
        chk("load_state", 128'({v1, busy1}), 128'(2'b01));
        @(negedge clk);
        chk("valid_2cyc", 128'(v1), 128'(1));
        chk("first_beat", 128'({ci1, cr1}), 128'({16'h04b0, 64'hf818_f810_f808_f800}));
        b = 0; cyc = 0; cnt = 0;
        while (b < 76800 && cyc < 80000) begin
            if (fd1) cnt++;
            if (v1) begin
                chk("f1_beat", 128'(cur1), 128'(model(16'hf800, 16'h04b0, 16'd8, 160, b)));
                if (b == 160) begin
                    chk("b160_py", 128'(py1), 128'(1));
                    chk("b160_ci", 128'(ci1), 128'(16'h04a8));
                    chk("b160_l0", 128'(cr1[15:0]), 128'(16'hf800));
                end
                b++;
            end else chk("f1_valid", 128'(v1), 128'(1));
            start = (b == 5);
            if (b == 5) begin x_min = 16'h1234; zoom_level = 2; end
            @(negedge clk); cyc++;
        end
        start = 0;
        chk("f1_beats", 128'(b), 128'(76800));
        chk("f1_fd_early", 128'(cnt), 128'(0));
        chk("f1_done", 128'({v1, busy1, fd1}), 128'(3'b011));
        @(negedge clk);
        chk("f1_idle", 128'({busy1, fd1}), 128'(2'b00));

        // random 30% ready, then abort at beat 100
        x_min = 16'hf800; zoom_level = 0; start = 1;
        @(negedge clk) start = 0;
        @(negedge clk);
        b = 0; cyc = 0;
        while (cyc < 2000) begin
            chk("st_beat", 128'({v1, cur1}), 128'({1'b1, model(16'hf800, 16'h04b0, 16'd8, 160, b)}));
            if (b == 100) begin abort = 1; break; end
            out_ready = $urandom_range(0, 9) < 3;
            if (out_ready) b++;
            @(negedge clk); cyc++;
        end
        chk("st_reach", 128'(b), 128'(100));
        @(negedge clk) abort = 0;
        chk("ab_done", 128'({v1, busy1, fd1}), 128'(3'b011));
        @(negedge clk);
        chk("ab_idle", 128'({busy1, fd1}), 128'(2'b00));
        cnt = 0;
        repeat (3) @(negedge clk) if (fd1) cnt++;
        chk("ab_fd_once", 128'(cnt), 128'(0));
        out_ready = 1; start = 1;
        @(negedge clk) start = 0;
        @(negedge clk);
        chk("ab_restart", 128'({v1, cur1}), 128'({1'b1, model(16'hf800, 16'h04b0, 16'd8, 160, 0)}));
        abort = 1;
        @(negedge clk) abort = 0;
        repeat (2) @(negedge clk);

        // zoom 3: 1 LSB step both unclamped and clamped, with 16-bit wrap; abort on final beat
        x_min = 16'h7ffe; y_max = 16'h0100; zoom_level = 3; start = 1;
        @(negedge clk) start = 0;
        @(negedge clk);
        chk("z3_lanes", 128'(cr1), 128'(64'h8001_8000_7fff_7ffe));
        chk("z3_clamp", 128'(cr2), 128'(64'h8001_8000_7fff_7ffe));
        for (int i = 0; i < 4; i++) begin
            chk("d2_beat", 128'({v2, cur2}), 128'({1'b1, model(16'h7ffe, 16'h0100, 16'd1, 2, i)}));
            if (i == 1) chk("d2_b1_l0", 128'(cr2[15:0]), 128'(16'h8002));
            if (i == 2) chk("d2_row1", 128'({ci2, cr2}), 128'({16'h00ff, 64'h8001_8000_7fff_7ffe}));
            abort = (i == 3);
            @(negedge clk);
        end
        abort = 0;
        chk("d2_fd", 128'({v2, fd2}), 128'(2'b01));
        cnt = 0;
        repeat (4) @(negedge clk) if (fd2) cnt++;
        chk("d2_fd_once", 128'({cnt, busy2}), 128'({32'd0, 1'b0}));

        // asynchronous reset while stalled
        x_min = 16'hf800; y_max = 16'h04b0; zoom_level = 0; out_ready = 0; start = 1;
        @(negedge clk) start = 0;
        repeat (3) @(negedge clk);
        chk("stall_hold", 128'({v1, cur1}), 128'({1'b1, model(16'hf800, 16'h04b0, 16'd8, 160, 0)}));
        #2 rst_n = 0;
        #1 chk("arst_outs", 128'({v1, busy1, fd1, cur1}), 128'(0));
        cnt = 0;
        repeat (3) @(negedge clk) if (fd1) cnt++;
        chk("arst_no_fd", 128'(cnt), 128'(0));
        rst_n = 1; out_ready = 1; start = 1;
        @(negedge clk) start = 0;
        @(negedge clk);
        chk("post_rst", 128'({v1, cur1}), 128'({1'b1, model(16'hf800, 16'h04b0, 16'd8, 160, 0)}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/coord_gen.md
COORD_GEN -- requirements
Module: coord_gen

Interface
REQ-001 Parameter Q, default 11: fractional bits of the signed fixed-point coordinate format.
REQ-002 Parameter N, default 16: total coordinate width in bits, two's complement.
REQ-003 Parameter LANES, default 4: number of horizontally adjacent pixels issued per beat; legal range 1..8.
REQ-004 Parameters H_RES and V_RES, defaults 640 and 480: frame size in pixels; H_RES SHALL be a multiple of LANES.
REQ-005 Parameter GRID_SH, default 3: grid step at zoom 0 is 2^GRID_SH LSBs.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 start  in  1  single-cycle frame request.
REQ-009 abort  in  1  terminates a running frame.
REQ-010 x_min  in  N  real coordinate of pixel column 0.
REQ-011 y_max  in  N  imaginary coordinate of pixel row 0.
REQ-012 zoom_level  in  2  grid selector.
REQ-013 out_valid  out  1  beat present on the output ports.
REQ-014 out_ready  in  1  consumer accepts the beat.
REQ-015 c_real  out  LANES*N  lane k occupies bits [k*N +: N].
REQ-016 c_img  out  N  imaginary coordinate shared by all lanes.
REQ-017 px_x  out  16  pixel column of lane 0.
REQ-018 px_y  out  16  pixel row.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 frame_done  out  1  one-cycle pulse at frame end.

Function
REQ-021 States are IDLE, LOAD, RUN, and DONE.
- IDLE->LOAD on start.
- LOAD->RUN after exactly one cycle.
- RUN->DONE on the handshake of the last beat, or on abort.
- DONE->IDLE after one cycle.
REQ-022 In IDLE, start SHALL latch x_min, y_max, and zoom_level; later changes to these inputs SHALL have no effect until the next frame.
REQ-023 Start while busy is high SHALL be ignored.
REQ-024 The grid step g SHALL equal 2^(GRID_SH - zoom_level) LSBs; when zoom_level > GRID_SH, g SHALL clamp to 1 LSB.
REQ-025 LOAD SHALL precompute the lane offsets k*g and the row stride LANES*g; no multiplier is used after LOAD.
REQ-026 For each beat, lane k SHALL output c_real = x_min + (px_x + k)*g, and c_img SHALL equal y_max - px_y*g.
REQ-027 The coordinate arithmetic SHALL use an incremental accumulator:
- the accumulator adds LANES*g per beat;
- at row end it reloads x_min;
- at row end c_img is decremented by g.
REQ-028 All additions SHALL wrap modulo 2^N, with no saturation and no overflow flag.
REQ-029 Beat order SHALL be raster order: px_x = 0, LANES, 2*LANES, ..., H_RES-LANES, then px_y increments; there are H_RES*V_RES/LANES beats per frame.
REQ-030 out_valid SHALL rise on the first cycle of RUN, two cycles after the start cycle.
REQ-031 A beat advances only when out_valid and out_ready are both high in the same cycle; one beat per cycle SHALL be sustained while out_ready is held high.
REQ-032 While out_valid is high and out_ready is low, c_real, c_img, px_x, and px_y SHALL hold stable.
REQ-033 out_valid SHALL NOT deassert without a handshake, except on abort.
REQ-034 All outputs SHALL be registered, with no combinational path from out_ready to any output other than through the registers.
REQ-035 abort in RUN SHALL drop out_valid on the next cycle and enter DONE.
REQ-036 abort coincident with the final handshake SHALL count that beat as accepted, and frame_done SHALL pulse once.
REQ-037 abort outside RUN SHALL be ignored.
REQ-038 frame_done SHALL be high exactly during the DONE cycle, for both normal completion and abort.

Reset
REQ-039 Asserting rst_n low SHALL immediately force the following, regardless of clock:
- state to IDLE;
- out_valid, busy, and frame_done to 0;
- c_real, c_img, px_x, px_y, and the latched parameters to 0.
REQ-040 Reset asserted mid-frame SHALL discard the frame.
REQ-041 The first start accepted after reset deassertion SHALL produce a complete frame beginning at px_x = 0, px_y = 0.

Verification
REQ-042 Defaults, x_min=16'hf800, y_max=16'h04b0, zoom 0, out_ready=1, start pulse -> out_valid is high 2 cycles later; first beat c_real lanes = f800/f808/f810/f818, c_img = 04b0; beat 160 has px_y=1, c_img=04a8, c_real lane 0 = f800; frame_done after 76800 beats.
REQ-043 zoom 3, then zoom 3 with GRID_SH=2 -> lane step 1 LSB in both cases (clamp); x_min=16'h7ffe wraps to 16'h8000 within a beat.
REQ-044 Random out_ready at 30% duty -> outputs stable while stalled; beat sequence identical to the REQ-042 run; no beat dropped or duplicated.
REQ-045 Start pulsed during RUN, plus x_min/zoom changes mid-frame -> ignored; frame uses the values latched at start.
REQ-046 Abort at beat 100 -> out_valid drops next cycle; one frame_done; busy falls; a new start yields px_x=0, px_y=0.
REQ-047 rst_n pulsed low mid-stall -> all outputs 0 without a clock edge; no frame_done pulse.
